// File: rtl/scs_decoder.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : scs_decoder                                                |
// | Description : Decodes 32-bit link flits made of two invert-coded 16-bit  |
// |               halves. Decoded data is buffered in a DEPTH-entry FIFO.    |
// |               The FIFO head is held in a register that drives out_data.  |
// |               Optional statistics counters are enabled by defining the   |
// |               macro SCS_DEC_STATS_EN.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module scs_decoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_flit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef SCS_DEC_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] inv_cnt,
  output logic [15:0] flit_cnt
`endif
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  // Only power-of-two depths from 2 to 16 are supported.
  generate
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("scs_decoder: DEPTH must be a power of two between 2 and 16");
    end
  endgenerate

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW-1:0] wr_ptr_inc;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [31:0]   head_q;
  logic [31:0]   head_d;
  logic [31:0]   mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   dec_flit;

  // Pointer advance with explicit wrap from the last entry back to zero.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + 1'b1;
    end
    return r;
  endfunction

  // Handshake: full blocks writes even when a pop happens on the same edge.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign rd_ptr_inc = ptr_next(rd_ptr_q);
  assign wr_ptr_inc = ptr_next(wr_ptr_q);

  // Each half: flip the 15 payload bits when its flag is set; bit 15 is zero.
  always_comb begin
    dec_flit = {1'b0, in_flit[30:16] ^ {15{in_flit[31]}},
                1'b0, in_flit[14:0]  ^ {15{in_flit[15]}}};
  end

  // Next-state for pointers, occupancy and the head register.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_inc : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_inc : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The head register tracks mem[rd_ptr]; when the FIFO drains to the
    // entry being written this cycle, the new flit bypasses the array.
    head_d = head_q;
    if (pop) begin
      if (count_q == CNT_ONE) begin
        if (push) begin
          head_d = dec_flit;
        end
      end else begin
        head_d = mem_q[rd_ptr_inc];
      end
    end else if (push && (count_q == '0)) begin
      head_d = dec_flit;
    end
  end

  // Control state: asynchronously cleared, updated on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array holds decoded data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec_flit;
    end
  end

`ifdef SCS_DEC_STATS_EN
  logic [15:0] inv_cnt_q;
  logic [15:0] inv_cnt_d;
  logic [15:0] flit_cnt_q;
  logic [15:0] flit_cnt_d;
  logic [16:0] inv_sum;

  assign inv_cnt  = inv_cnt_q;
  assign flit_cnt = flit_cnt_q;

  // Saturating counters; a clear wins over an accept on the same edge.
  always_comb begin
    inv_sum    = {1'b0, inv_cnt_q} + 17'(in_flit[31]) + 17'(in_flit[15]);
    inv_cnt_d  = inv_cnt_q;
    flit_cnt_d = flit_cnt_q;
    if (stats_clr) begin
      inv_cnt_d  = 16'h0;
      flit_cnt_d = 16'h0;
    end else if (push) begin
      inv_cnt_d  = inv_sum[16] ? 16'hFFFF : inv_sum[15:0];
      flit_cnt_d = (flit_cnt_q == 16'hFFFF) ? 16'hFFFF : flit_cnt_q + 1'b1;
    end
  end

  // Statistics registers share the asynchronous reset with the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt_q  <= 16'h0;
      flit_cnt_q <= 16'h0;
    end else begin
      inv_cnt_q  <= inv_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/scs_decoder.md
SCS_DECODER -- requirements
Module: scs_decoder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; the module SHALL support only powers of two from 2 to 16.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: an encoded flit is present on in_flit.
REQ-005 Port in_ready, output, 1 bit: the block can accept a flit this cycle.
REQ-006 Port in_flit, input, 32 bits: link flit. Bits [31] and [15] are the invert flags of the upper and lower halves; bits [30:16] and [14:0] are the payload.
REQ-007 Port out_valid, output, 1 bit: decoded data is present on out_data.
REQ-008 Port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-009 Port out_data, output, 32 bits: the decoded flit.
REQ-010 Port stats_clr, input, 1 bit: synchronous clear of the statistics counters; only present under SCS_DEC_STATS_EN.
REQ-011 Port inv_cnt, output, 16 bits: count of inverted halves received; only present under SCS_DEC_STATS_EN.
REQ-012 Port flit_cnt, output, 16 bits: count of flits accepted; only present under SCS_DEC_STATS_EN.

Function
REQ-013 A flit SHALL be accepted on any rising edge where in_valid && in_ready.
REQ-014 The decode of each 16-bit half h SHALL be payload[14:0] XOR {15{flag}}; decoded bit 15 of each half SHALL be 0.
REQ-015 The decode SHALL be applied combinationally at FIFO write; the FIFO SHALL store decoded data only.
REQ-016 The FIFO SHALL be DEPTH entries and first-in first-out, using wrap-around read/write pointers and an occupancy counter of clog2(DEPTH)+1 bits.
REQ-017 in_ready SHALL equal (count != DEPTH); there is no bypass.
REQ-018 When full, simultaneous pop and push SHALL NOT be allowed: in_ready SHALL stay low that cycle.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL come from a register holding the head entry.
REQ-020 Latency SHALL be one cycle: a flit accepted at edge N into an empty FIFO SHALL show out_valid=1 after edge N.
REQ-021 A pop SHALL occur on any edge where out_valid && out_ready.
REQ-022 When push and pop happen on the same edge and the FIFO is not full, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When the FIFO is not full, a push and a pop on the same edge at count==1 SHALL present the new flit on the next cycle.
REQ-024 out_data and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously clear, at any time including mid-transfer:
- pointers and count to 0;
- out_valid to 0;
- out_data to 32'h0;
- inv_cnt and flit_cnt to 0.
REQ-027 During reset, in_ready SHALL read 1 as soon as count is 0.
REQ-028 Accepts SHALL occur from the first clock edge after rst_n deasserts.
REQ-029 FIFO storage contents SHALL NOT need reset.

Configuration
REQ-030 When macro SCS_DEC_STATS_EN is defined, the three statistics ports and their counters SHALL exist.
REQ-031 On each accept, flit_cnt SHALL increment by 1.
REQ-032 On each accept, inv_cnt SHALL increment by in_flit[31]+in_flit[15], i.e. 0, 1 or 2.
REQ-033 Both counters SHALL saturate at 16'hFFFF.
REQ-034 stats_clr SHALL take priority over a same-cycle increment.
REQ-035 When SCS_DEC_STATS_EN is not defined, the statistics ports and logic SHALL be absent; FIFO and decode behaviour SHALL be identical in both builds.

Verification
REQ-036 Send in_flit=32'h8000_0000 with out_ready=1 -> one cycle later out_data=32'h7FFF_0000, out_valid=1.
REQ-037 Send in_flit=32'h1234_8005 -> out_data=32'h1234_7FFA.
REQ-038 Hold out_ready=0 and offer 5 flits with DEPTH=4 -> in_ready=0 after 4 accepts; the 5th flit is held. Raising out_ready then drains the flits in order with no loss or duplicate.
REQ-039 At count=2, push and pop on the same edge -> count stays 2 and the order is preserved; at count=DEPTH, in_ready=0 even while popping.
REQ-040 Pull rst_n low mid-burst at count=3 -> out_valid=0 and in_ready=1 immediately, before any clock edge; after release, the next flit sent has 1-cycle latency.
REQ-041 With SCS_DEC_STATS_EN defined, send 3 flits with flags {1,1},{0,1},{0,0} -> flit_cnt=3, inv_cnt=3.
REQ-042 With inv_cnt preset near 16'hFFFF, send further flags -> inv_cnt holds at 16'hFFFF.
REQ-043 Assert stats_clr together with an accept -> both counters read 0.
